dsi_crc_chk: RTL
================

// Module: dsi_crc_chk
// PURPOSE
//  Receive-side checker for the DSI long-packet payload CRC. Sits after the deserialiser / depacketiser.
//  Accepts a frame of FRAME_LENGTH 24-bit pixel words, one word per cycle, and recomputes the 16-bit CRC
//  bit-for-bit as the transmit-side generator does. Compares the result with the received CRC and flags pass/fail.
// PARAMETERS
//  FRAME_LENGTH  4         payload words per frame (>=1)
//  WORD_W        24        bits per payload word
//  POLY          16'hCAFE  CRC polynomial, matches transmit generator
//  SEED          16'h0000  CRC value loaded at start of frame
// PORTS
//  dsi_clk     in   1       single clock, all logic on posedge
//  dsi_rst     in   1       synchronous, active-high reset
//  sof         in   1       start-of-frame pulse; loads SEED, enters ACCUM
//  word_valid  in   1       payload word present on word_data
//  word_data   in   WORD_W  payload word; first word of frame = most-significant word of payload
//  word_ready  out  1       checker accepts a word this cycle
//  crc_valid   in   1       received CRC present on crc_rx
//  crc_rx      in   16      CRC received from the link
//  crc_calc    out  16      running / final computed CRC
//  chk_done    out  1       1-cycle pulse: result valid
//  crc_ok      out  1       held from chk_done until next sof/reset: CRC matched, length correct
//  crc_err     out  1       held from chk_done until next sof/reset: mismatch or length error
//  len_err     out  1       held from chk_done until next sof/reset: crc_valid arrived before FRAME_LENGTH words
// BEHAVIOUR
//  Reset (dsi_rst=1 at posedge): state=IDLE.
//   word_ready=0, crc_calc=SEED, chk_done=0, crc_ok=0, crc_err=0, len_err=0, word count=0.
//   Reset mid-frame abandons the frame with no chk_done.
//  CRC update per bit b, processed MSB first (bit WORD_W-1 of word down to bit 0):
//   if (crc[15]^b) crc = {crc[14:0],1'b1} ^ POLY; else crc = {crc[14:0],1'b0}.
//   A whole word (24 iterations) is folded in one cycle; crc_calc updates the cycle after acceptance.
//  FSM:
//   IDLE  : word_ready=0; word_valid/crc_valid ignored.
//           sof -> ACCUM, crc_calc=SEED, count=0, crc_ok/crc_err/len_err cleared.
//   ACCUM : word_ready=1; accept when word_valid&word_ready; count++.
//           Accept of word FRAME_LENGTH -> WAIT_CRC.
//           crc_valid with count<FRAME_LENGTH -> DONE, len_err=1, crc_err=1.
//           A word and crc_valid in the same cycle: word accepted first, then the length check uses the new count.
//   WAIT_CRC: word_ready=0; extra words are not accepted.
//           crc_valid -> DONE; crc_ok=(crc_rx==crc_calc), crc_err=~crc_ok.
//   DONE  : chk_done=1 for exactly this one cycle -> IDLE; crc_ok/crc_err/len_err hold.
//  Latency: chk_done is asserted the cycle after crc_valid is sampled.
//  sof in any non-IDLE state restarts the frame: SEED reloaded, count=0, flags cleared, no chk_done for the
//   aborted frame. sof has priority over word_valid/crc_valid in the same cycle.
//  Counter is $clog2(FRAME_LENGTH+1) bits wide; it never wraps (it saturates via the state change).
//  crc_calc holds its final value after DONE until the next sof or reset.
// TESTING
//  1 FRAME_LENGTH=4; sof, words 0,0,0,0; crc_rx=16'h0000 -> crc_calc=0000, chk_done 1 cycle after crc_valid, crc_ok=1.
//  2 words 0,0,0,24'h000001; crc_rx=16'hCAFF -> crc_ok=1.
//    Same frame with crc_rx=16'hCAFE -> crc_err=1, len_err=0.
//  3 words 0,0,0,24'h000002; crc_rx=16'h5F01 -> crc_ok=1 (checks MSB-first order and the shifted-in 1).
//  4 sof, 2 words, then crc_valid -> chk_done, len_err=1, crc_err=1, crc_ok=0.
//  5 word_valid toggled 1/0 each cycle across 4 words -> only handshaked words counted; result matches scenario 1.
//  6 sof mid-ACCUM after 2 words, then a full clean frame -> single chk_done, crc_ok=1.
//    dsi_rst asserted mid-frame -> all outputs 0 next cycle, no chk_done.

Source files
------------

// File: rtl/dsi_crc_chk.sv
// dsi_crc_chk: receive-side checker for the DSI long-packet payload CRC.
// Folds one payload word per cycle into a running 16-bit CRC (MSB first),
// then compares it with the CRC received from the link and reports
// pass / CRC mismatch / short-frame length error.
module dsi_crc_chk #(
    parameter int          FRAME_LENGTH = 4,
    parameter int          WORD_W       = 24,
    parameter logic [15:0] POLY         = 16'hCAFE,
    parameter logic [15:0] SEED         = 16'h0000
) (
    input  logic              dsi_clk,
    input  logic              dsi_rst,
    input  logic              sof,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    input  logic              crc_valid,
    input  logic [15:0]       crc_rx,
    output logic [15:0]       crc_calc,
    output logic              chk_done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic              len_err
);

    localparam int CNT_W = $clog2(FRAME_LENGTH + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LENGTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCUM    = 2'd1;
    localparam logic [1:0] ST_WAIT_CRC = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Fold a whole word into the CRC, MSB first. On feedback the shifted-in
    // bit is 1 before the polynomial XOR, matching the transmit generator.
    function automatic logic [15:0] crc_fold(input logic [15:0] crc_in,
                                             input logic [WORD_W-1:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b1} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [1:0]       state_r;
    logic [15:0]      crc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ok_r;
    logic             err_r;
    logic             len_r;
    logic             done_r;
    logic             ready_r;

    logic [1:0]       state_nxt_s;
    logic [15:0]      crc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ok_nxt_s;
    logic             err_nxt_s;
    logic             len_nxt_s;
    logic             done_nxt_s;
    logic             accept_s;
    logic [15:0]      acc_crc_s;
    logic [CNT_W-1:0] acc_cnt_s;

    // Next-state, CRC accumulation and verdict logic; sof overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        crc_nxt_s   = crc_r;
        cnt_nxt_s   = cnt_r;
        ok_nxt_s    = ok_r;
        err_nxt_s   = err_r;
        len_nxt_s   = len_r;
        done_nxt_s  = 1'b0;
        accept_s    = word_valid & ready_r;
        acc_crc_s   = crc_r;
        acc_cnt_s   = cnt_r;

        if (sof) begin
            state_nxt_s = ST_ACCUM;
            crc_nxt_s   = SEED;
            cnt_nxt_s   = CNT_ZERO;
            ok_nxt_s    = 1'b0;
            err_nxt_s   = 1'b0;
            len_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ACCUM: begin
                    // A word in the same cycle as crc_valid is folded first,
                    // so the length check sees the updated count.
                    if (accept_s) begin
                        acc_crc_s = crc_fold(crc_r, word_data);
                        acc_cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        acc_crc_s = crc_r;
                        acc_cnt_s = cnt_r;
                    end
                    crc_nxt_s = acc_crc_s;
                    cnt_nxt_s = acc_cnt_s;
                    if (crc_valid) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        if (acc_cnt_s == CNT_FRAME) begin
                            ok_nxt_s  = (crc_rx == acc_crc_s);
                            err_nxt_s = (crc_rx != acc_crc_s);
                            len_nxt_s = 1'b0;
                        end else begin
                            ok_nxt_s  = 1'b0;
                            err_nxt_s = 1'b1;
                            len_nxt_s = 1'b1;
                        end
                    end else if (acc_cnt_s == CNT_FRAME) begin
                        state_nxt_s = ST_WAIT_CRC;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_WAIT_CRC: begin
                    if (crc_valid) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        ok_nxt_s    = (crc_rx == crc_r);
                        err_nxt_s   = (crc_rx != crc_r);
                        len_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_WAIT_CRC;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; ready and done are pre-decoded from the next state.
    always_ff @(posedge dsi_clk) begin
        if (dsi_rst) begin
            state_r <= ST_IDLE;
            crc_r   <= SEED;
            cnt_r   <= CNT_ZERO;
            ok_r    <= 1'b0;
            err_r   <= 1'b0;
            len_r   <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            crc_r   <= crc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ok_r    <= ok_nxt_s;
            err_r   <= err_nxt_s;
            len_r   <= len_nxt_s;
            done_r  <= done_nxt_s;
            ready_r <= (state_nxt_s == ST_ACCUM);
        end
    end

    assign word_ready = ready_r;
    assign crc_calc   = crc_r;
    assign chk_done   = done_r;
    assign crc_ok     = ok_r;
    assign crc_err    = err_r;
    assign len_err    = len_r;

endmodule
